partitioned_cache_set: RTL and testbench
========================================

# partitioned_cache_set

Parametrised, multi-domain successor to the single-line way-partitioned cache. The block holds one set of `NUM_WAYS` ways. OS requests give each security domain an exclusive way mask. User requests look up and fill only inside the requesting domain's mask, so one domain can never observe another's tags or replacement state. Internal state is exported to the two-copy noninterference harness so that formal invariants can be written against it.

## Interface
- `NUM_WAYS`, 8: ways in the set (≥2).
- `ADDR_WIDTH`, 8: tag width.
- `NUM_DOMAINS`, 4: security domains (≥2).
- `DOM_W`, $clog2(NUM_DOMAINS): domain id width (derived).

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `os_req` in 1: repartition request.
- `os_domain` in DOM_W: domain being assigned.
- `os_hitmap` in NUM_WAYS: new way mask for `os_domain`.
- `os_err` out 1: one-cycle pulse when a request is rejected.
- `user_req` in 1: lookup request.
- `user_domain` in DOM_W: requesting domain.
- `addr` in ADDR_WIDTH: tag to look up.
- `resp_valid` out 1: response strobe.
- `hit` out 1: lookup hit.
- `hit_way` out NUM_WAYS: one-hot way that hit or was filled; 0 if none.
- `all_tags_o` out ADDR_WIDTH*NUM_WAYS: way i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `all_valid_o` out NUM_WAYS: valid bits.
- `owned_o` out NUM_WAYS: way has an owner.
- `owner_o` out DOM_W*NUM_WAYS: owner id per way.
- `rr_ptr_o` out $clog2(NUM_WAYS)*NUM_DOMAINS: per-domain replacement pointers.

## Operation
Per-way state: `valid`, `tag`, `owned`, `owner`. Per-domain state: round-robin pointer `rr[d]`. The mask of domain d is defined as `M(d)[i] = owned[i] && owner[i]==d`.

OS request (`os_req`=1):
- Legal iff `os_hitmap != 0` and every set way is either unowned or already owned by `os_domain`.
- Illegal: `os_err`=1 for one cycle; no state change.
- Legal:
  - ways in `os_hitmap` become owned by `os_domain`;
  - ways in old `M(os_domain)` but not in `os_hitmap` become unowned, with valid=0 and tag=0;
  - newly granted ways get valid=0 and tag=0;
  - ways kept in the mask retain valid and tag;
  - `rr[os_domain]` is set to the lowest set bit of `os_hitmap`.

User request (`user_req`=1, `os_req`=0), domain d:
- Hit: some way i in `M(d)` has valid and `tag==addr`. At most one can match, because fills never duplicate.
  - Response: `hit`=1, `hit_way`=onehot(i). No state change.
- Miss with `M(d)` nonempty: a victim is chosen.
  - The victim is the lowest-index invalid way in `M(d)`.
  - If none is invalid, the victim is the way at `rr[d]`, and `rr[d]` advances to the next set bit of `M(d)` above it, wrapping to the lowest.
  - The victim gets valid=1 and tag=`addr`.
  - Response: `hit`=0, `hit_way`=onehot(victim).
- Miss with `M(d)` empty: `hit`=0, `hit_way`=0, no state change.

Collisions and isolation:
- `os_req` and `user_req` in the same cycle: OS wins, the user request is dropped, and `resp_valid` stays 0.
- Ways outside `M(d)` are never read for the hit decision and never written by a user request of d.
- `rr[e]` for e≠d never changes on d's requests.

## Timing
- Every output is registered. Reset values are all 0: `os_err`, `resp_valid`, `hit`, `hit_way`, and all state. Every way is unowned and invalid, and every `rr` is 0.
- User request sampled at edge t: `resp_valid`, `hit` and `hit_way` are valid for the cycle after t. Fill and `rr` update are visible at t+1.
- `resp_valid`, `hit`, `hit_way` and `os_err` are single-cycle pulses.
- OS request sampled at t: the new masks apply to a user request sampled at t+1.
- Throughput is one request per cycle, with no backpressure.
- Back-to-back requests from the same domain see the previous fill.
- Reset asserted mid-operation clears all state asynchronously. A response pending for the next cycle is lost.

## Structure
- Shared package/header `cache_part_consts`: default widths, `DOM_W`/pointer-width helpers, one-hot and priority-encode functions.
- Sub-module `way_select`, combinational:
  - inputs: mask, valid vector, `rr`;
  - outputs: the lowest invalid way in the mask, an any-invalid flag, and the next `rr`.
- It is instantiated once, in the user path.
- Ways and domains are built with generate loops. No memory macros.

## Test plan
- Reset, then user_req d0 with addr 0x12: `resp_valid`=1, `hit`=0, `hit_way`=0 (no ways owned); no state change.
- os_req d1 with mask 0x0F; user_req d1 at 0x12 → miss, fill way0; user_req d1 at 0x12 again → `hit`=1, `hit_way`=0x01.
- os_req d2 with mask 0x18, while d1 holds 0x0F → `os_err` pulse. All owner, valid and tag state is unchanged.
- d1 fills 0x01..0x04 into ways 0-3. A 5th distinct miss (0x05) replaces way0, and `rr[1]` goes to 1. A 6th miss (0x06) replaces way1.
- d1 shrinks to mask 0x03 → ways 2,3 become unowned, invalid, tag 0. Then os_req d2 with mask 0x0C is accepted with fresh invalid ways. d2 looking up a tag that d1 held → miss.
- Same-cycle os_req and user_req → user request dropped (`resp_valid`=0). Async reset mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/cache_part_consts.sv
// Shared constants and helpers for the partitioned cache set: default sizes,
// id-width helper, one-hot and lowest-set-bit encoders (up to 32 ways).
package cache_part_consts;

  localparam int DEF_NUM_WAYS    = 8;
  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_NUM_DOMAINS = 4;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [31:0] onehot32(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [31:0] lowest_idx32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = 32'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/partitioned_cache_set_way_select.sv
// Victim helper for the user path: lowest invalid way inside the domain mask
// and the round-robin successor of the domain's pointer within that mask.
module way_select
  import cache_part_consts::*;
#(
  parameter int NUM_WAYS = DEF_NUM_WAYS,
  parameter int PTR_W    = id_width(DEF_NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] i_mask,
  input  logic [NUM_WAYS-1:0] i_valid,
  input  logic [PTR_W-1:0]    i_rr,
  output logic [PTR_W-1:0]    o_inv_idx,
  output logic                o_any_inv,
  output logic [PTR_W-1:0]    o_rr_next
);

  logic [NUM_WAYS-1:0] w_inv;
  logic [NUM_WAYS-1:0] w_above;
  logic [NUM_WAYS-1:0] w_above_mask;

  assign w_inv     = i_mask & ~i_valid;
  assign o_any_inv = |w_inv;
  assign o_inv_idx = PTR_W'(lowest_idx32(32'(w_inv)));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_above
      assign w_above[gi] = (gi > int'(i_rr));
    end
  endgenerate

  // Next owned way strictly above the pointer, else wrap to the lowest owned way.
  assign w_above_mask = i_mask & w_above;
  assign o_rr_next    = (|w_above_mask) ? PTR_W'(lowest_idx32(32'(w_above_mask)))
                                        : PTR_W'(lowest_idx32(32'(i_mask)));

endmodule

// File: rtl/partitioned_cache_set.sv
// One cache set whose ways are exclusively partitioned between security
// domains; user lookups and fills only ever touch the requester's own ways.
module partitioned_cache_set
  import cache_part_consts::*;
#(
  parameter int NUM_WAYS    = DEF_NUM_WAYS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int DOM_W       = id_width(NUM_DOMAINS)
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       os_req,
  input  logic [DOM_W-1:0]                           os_domain,
  input  logic [NUM_WAYS-1:0]                        os_hitmap,
  output logic                                       os_err,
  input  logic                                       user_req,
  input  logic [DOM_W-1:0]                           user_domain,
  input  logic [ADDR_WIDTH-1:0]                      addr,
  output logic                                       resp_valid,
  output logic                                       hit,
  output logic [NUM_WAYS-1:0]                        hit_way,
  output logic [ADDR_WIDTH*NUM_WAYS-1:0]             all_tags_o,
  output logic [NUM_WAYS-1:0]                        all_valid_o,
  output logic [NUM_WAYS-1:0]                        owned_o,
  output logic [DOM_W*NUM_WAYS-1:0]                  owner_o,
  output logic [id_width(NUM_WAYS)*NUM_DOMAINS-1:0]  rr_ptr_o
);

  localparam int PTR_W = id_width(NUM_WAYS);

  logic                  r_valid [NUM_WAYS];
  logic [ADDR_WIDTH-1:0] r_tag   [NUM_WAYS];
  logic                  r_owned [NUM_WAYS];
  logic [DOM_W-1:0]      r_owner [NUM_WAYS];
  logic [PTR_W-1:0]      r_rr    [NUM_DOMAINS];

  logic                  r_os_err;
  logic                  r_resp_valid;
  logic                  r_hit;
  logic [NUM_WAYS-1:0]   r_hit_way;

  logic [NUM_WAYS-1:0]   w_mask_os;
  logic [NUM_WAYS-1:0]   w_mask_user;
  logic [NUM_WAYS-1:0]   w_valid_vec;
  logic [NUM_WAYS-1:0]   w_match;
  logic [NUM_WAYS-1:0]   w_conflict;
  logic                  w_os_legal;
  logic                  w_user_go;
  logic                  w_hit;
  logic                  w_mask_any;
  logic                  w_fill;
  logic [PTR_W-1:0]      w_rr_cur;
  logic [PTR_W-1:0]      w_inv_idx;
  logic                  w_any_inv;
  logic [PTR_W-1:0]      w_rr_next;
  logic [PTR_W-1:0]      w_victim_idx;
  logic [NUM_WAYS-1:0]   w_victim_oh;
  logic [PTR_W-1:0]      w_os_rr;

  assign w_os_legal   = (|os_hitmap) && !(|w_conflict);
  assign w_user_go    = user_req && !os_req;
  assign w_hit        = |w_match;
  assign w_mask_any   = |w_mask_user;
  assign w_fill       = w_user_go && !w_hit && w_mask_any;
  assign w_victim_idx = w_any_inv ? w_inv_idx : w_rr_cur;
  assign w_victim_oh  = NUM_WAYS'(onehot32(32'(w_victim_idx)));
  assign w_os_rr      = PTR_W'(lowest_idx32(32'(os_hitmap)));

  always_comb begin
    w_rr_cur = '0;
    for (int d = 0; d < NUM_DOMAINS; d++) begin
      if (user_domain == DOM_W'(d)) w_rr_cur = r_rr[d];
    end
  end

  way_select #(
    .NUM_WAYS (NUM_WAYS),
    .PTR_W    (PTR_W)
  ) u_way_select (
    .i_mask    (w_mask_user),
    .i_valid   (w_valid_vec),
    .i_rr      (w_rr_cur),
    .o_inv_idx (w_inv_idx),
    .o_any_inv (w_any_inv),
    .o_rr_next (w_rr_next)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      assign w_mask_os[gi]   = r_owned[gi] && (r_owner[gi] == os_domain);
      assign w_mask_user[gi] = r_owned[gi] && (r_owner[gi] == user_domain);
      assign w_valid_vec[gi] = r_valid[gi];
      assign w_match[gi]     = w_mask_user[gi] && r_valid[gi] && (r_tag[gi] == addr);
      assign w_conflict[gi]  = os_hitmap[gi] && r_owned[gi] && (r_owner[gi] != os_domain);

      // Granted ways start empty; kept ways retain contents; released ways are scrubbed.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_valid[gi] <= 1'b0;
          r_tag[gi]   <= '0;
          r_owned[gi] <= 1'b0;
          r_owner[gi] <= '0;
        end else if (os_req) begin
          if (w_os_legal) begin
            if (os_hitmap[gi]) begin
              r_owned[gi] <= 1'b1;
              r_owner[gi] <= os_domain;
              if (!w_mask_os[gi]) begin
                r_valid[gi] <= 1'b0;
                r_tag[gi]   <= '0;
              end
            end else if (w_mask_os[gi]) begin
              r_owned[gi] <= 1'b0;
              r_owner[gi] <= '0;
              r_valid[gi] <= 1'b0;
              r_tag[gi]   <= '0;
            end
          end
        end else if (w_fill && w_victim_oh[gi]) begin
          r_valid[gi] <= 1'b1;
          r_tag[gi]   <= addr;
        end
      end

      assign all_tags_o[gi*ADDR_WIDTH +: ADDR_WIDTH] = r_tag[gi];
      assign all_valid_o[gi]                         = r_valid[gi];
      assign owned_o[gi]                             = r_owned[gi];
      assign owner_o[gi*DOM_W +: DOM_W]              = r_owner[gi];
    end

    for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
      // Pointer moves only when a full mask forces round-robin eviction.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_rr[gi] <= '0;
        end else if (os_req) begin
          if (w_os_legal && (os_domain == DOM_W'(gi))) r_rr[gi] <= w_os_rr;
        end else if (w_fill && !w_any_inv && (user_domain == DOM_W'(gi))) begin
          r_rr[gi] <= w_rr_next;
        end
      end

      assign rr_ptr_o[gi*PTR_W +: PTR_W] = r_rr[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_os_err     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_hit        <= 1'b0;
      r_hit_way    <= '0;
    end else begin
      r_os_err     <= os_req && !w_os_legal;
      r_resp_valid <= w_user_go;
      r_hit        <= w_user_go && w_hit;
      if (!w_user_go)      r_hit_way <= '0;
      else if (w_hit)      r_hit_way <= w_match;
      else if (w_mask_any) r_hit_way <= w_victim_oh;
      else                 r_hit_way <= '0;
    end
  end

  assign os_err     = r_os_err;
  assign resp_valid = r_resp_valid;
  assign hit        = r_hit;
  assign hit_way    = r_hit_way;

endmodule

// File: tb/tb_partitioned_cache_set.sv
// Scenario bench for partitioned_cache_set: user responses go through a queue
// scoreboard; OS results and exported state are checked inline per scenario.
module tb_partitioned_cache_set;

  localparam int NW = 8;
  localparam int AW = 8;
  localparam int ND = 4;
  localparam int DW = 2;
  localparam int PW = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             os_req;
  logic [DW-1:0]    os_domain;
  logic [NW-1:0]    os_hitmap;
  logic             os_err;
  logic             user_req;
  logic [DW-1:0]    user_domain;
  logic [AW-1:0]    addr;
  logic             resp_valid;
  logic             hit;
  logic [NW-1:0]    hit_way;
  logic [AW*NW-1:0] all_tags_o;
  logic [NW-1:0]    all_valid_o;
  logic [NW-1:0]    owned_o;
  logic [DW*NW-1:0] owner_o;
  logic [PW*ND-1:0] rr_ptr_o;

  typedef struct packed {
    logic          hit;
    logic [NW-1:0] way;
  } resp_t;

  resp_t sb_q[$];
  resp_t exp_r;
  int    checks = 0;
  int    errors = 0;

  partitioned_cache_set #(
    .NUM_WAYS    (NW),
    .ADDR_WIDTH  (AW),
    .NUM_DOMAINS (ND)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .os_req      (os_req),
    .os_domain   (os_domain),
    .os_hitmap   (os_hitmap),
    .os_err      (os_err),
    .user_req    (user_req),
    .user_domain (user_domain),
    .addr        (addr),
    .resp_valid  (resp_valid),
    .hit         (hit),
    .hit_way     (hit_way),
    .all_tags_o  (all_tags_o),
    .all_valid_o (all_valid_o),
    .owned_o     (owned_o),
    .owner_o     (owner_o),
    .rr_ptr_o    (rr_ptr_o)
  );

  always #5 clk = ~clk;

  // Response monitor: every strobe must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (resp_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got hit=%0b way=%02h required no response", hit, hit_way);
      end else begin
        exp_r = sb_q.pop_front();
        $display("resp hit=%0b way=%02h", hit, hit_way);
        if ({hit, hit_way} !== exp_r) begin
          errors++;
          $display("FAIL resp_data got hit=%0b way=%02h required hit=%0b way=%02h",
                   hit, hit_way, exp_r.hit, exp_r.way);
        end
      end
    end
  end

  task automatic do_user(input logic [DW-1:0] d, input logic [AW-1:0] a,
                         input logic eh, input logic [NW-1:0] ew);
    @(negedge clk);
    user_req    = 1'b1;
    user_domain = d;
    addr        = a;
    sb_q.push_back({eh, ew});
    $display("user d%0d addr %02h expect hit=%0b way=%02h", d, a, eh, ew);
    @(posedge clk);
    #1;
    user_req = 1'b0;
  endtask

  task automatic do_os(input logic [DW-1:0] d, input logic [NW-1:0] m, input logic e_err);
    @(negedge clk);
    os_req    = 1'b1;
    os_domain = d;
    os_hitmap = m;
    @(posedge clk);
    #1;
    os_req = 1'b0;
    $display("os d%0d map %02h os_err=%0b", d, m, os_err);
    checks++;
    if (os_err !== e_err) begin
      errors++;
      $display("FAIL os_err d%0d map %02h got %0b required %0b", d, m, os_err, e_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; os_req = 1'b0; user_req = 1'b0;
    os_domain = '0; os_hitmap = '0; user_domain = '0; addr = '0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({os_err, resp_valid, hit, hit_way} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got %03h required 000", {os_err, resp_valid, hit, hit_way});
    end
    checks++;
    if ({all_tags_o, all_valid_o, owned_o, owner_o, rr_ptr_o} !== '0) begin
      errors++;
      $display("FAIL reset_state got valid=%02h owned=%02h rr=%03h required all zero",
               all_valid_o, owned_o, rr_ptr_o);
    end
    do_user(2'd0, 8'h12, 1'b0, 8'h00);
    checks++;
    if ({all_valid_o, owned_o} !== 16'h0000) begin
      errors++;
      $display("FAIL unowned_no_fill got valid=%02h owned=%02h required 00", all_valid_o, owned_o);
    end
  endtask

  task automatic test_grant_and_hit();
    do_os(2'd1, 8'h0F, 1'b0);
    checks++;
    if ({owned_o, owner_o} !== {8'h0F, 16'h0055}) begin
      errors++;
      $display("FAIL grant_state got owned=%02h owner=%04h required 0f/0055", owned_o, owner_o);
    end
    do_user(2'd1, 8'h12, 1'b0, 8'h01);
    do_user(2'd1, 8'h12, 1'b1, 8'h01);
  endtask

  task automatic test_os_err();
    do_os(2'd2, 8'h18, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (os_err !== 1'b0) begin
      errors++;
      $display("FAIL os_err_pulse got %0b required 0", os_err);
    end
    checks++;
    if ({owned_o, owner_o, all_valid_o, all_tags_o} !== {8'h0F, 16'h0055, 8'h01, 64'h12}) begin
      errors++;
      $display("FAIL os_err_state got owned=%02h owner=%04h valid=%02h tags=%016h required 0f/0055/01/12",
               owned_o, owner_o, all_valid_o, all_tags_o);
    end
  endtask

  task automatic test_replacement();
    do_os(2'd1, 8'h0E, 1'b0);
    checks++;
    if ({owned_o, all_valid_o, all_tags_o, rr_ptr_o} !== {8'h0E, 8'h00, 64'h0, 12'h008}) begin
      errors++;
      $display("FAIL release_way0 got owned=%02h valid=%02h tags=%016h rr=%03h required 0e/00/0/008",
               owned_o, all_valid_o, all_tags_o, rr_ptr_o);
    end
    do_os(2'd1, 8'h0F, 1'b0);
    checks++;
    if (rr_ptr_o !== 12'h000) begin
      errors++;
      $display("FAIL regrant_rr got %03h required 000", rr_ptr_o);
    end
    do_user(2'd1, 8'h01, 1'b0, 8'h01);
    do_user(2'd1, 8'h02, 1'b0, 8'h02);
    do_user(2'd1, 8'h03, 1'b0, 8'h04);
    do_user(2'd1, 8'h04, 1'b0, 8'h08);
    do_user(2'd1, 8'h05, 1'b0, 8'h01);
    checks++;
    if (rr_ptr_o !== 12'h008) begin
      errors++;
      $display("FAIL rr_after_5th got %03h required 008", rr_ptr_o);
    end
    do_user(2'd1, 8'h06, 1'b0, 8'h02);
    checks++;
    if (rr_ptr_o !== 12'h010) begin
      errors++;
      $display("FAIL rr_after_6th got %03h required 010", rr_ptr_o);
    end
    do_user(2'd1, 8'h06, 1'b1, 8'h02);
    checks++;
    if ({all_valid_o, all_tags_o} !== {8'h0F, 64'h04030605}) begin
      errors++;
      $display("FAIL tags_after_evict got valid=%02h tags=%016h required 0f/04030605",
               all_valid_o, all_tags_o);
    end
    do_user(2'd1, 8'h07, 1'b0, 8'h04);
    do_user(2'd1, 8'h08, 1'b0, 8'h08);
    checks++;
    if (rr_ptr_o !== 12'h000) begin
      errors++;
      $display("FAIL rr_wrap got %03h required 000", rr_ptr_o);
    end
  endtask

  task automatic test_shrink_regrant();
    do_os(2'd1, 8'h03, 1'b0);
    checks++;
    if ({owned_o, owner_o, all_valid_o, all_tags_o} !== {8'h03, 16'h0005, 8'h03, 64'h0605}) begin
      errors++;
      $display("FAIL shrink_state got owned=%02h owner=%04h valid=%02h tags=%016h required 03/0005/03/0605",
               owned_o, owner_o, all_valid_o, all_tags_o);
    end
    do_os(2'd2, 8'h0C, 1'b0);
    checks++;
    if ({owned_o, owner_o, all_valid_o, rr_ptr_o} !== {8'h0F, 16'h00A5, 8'h03, 12'h080}) begin
      errors++;
      $display("FAIL regrant_state got owned=%02h owner=%04h valid=%02h rr=%03h required 0f/00a5/03/080",
               owned_o, owner_o, all_valid_o, rr_ptr_o);
    end
    do_user(2'd2, 8'h07, 1'b0, 8'h04);
    do_user(2'd2, 8'h05, 1'b0, 8'h08);
    do_user(2'd1, 8'h05, 1'b1, 8'h01);
    do_user(2'd3, 8'h05, 1'b0, 8'h00);
    checks++;
    if ({all_tags_o, rr_ptr_o} !== {64'h05070605, 12'h080}) begin
      errors++;
      $display("FAIL isolation_state got tags=%016h rr=%03h required 05070605/080", all_tags_o, rr_ptr_o);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    os_req = 1'b1; os_domain = 2'd3; os_hitmap = 8'h30;
    user_req = 1'b1; user_domain = 2'd1; addr = 8'h06;
    $display("collision os d3 map 30 with user d1 addr 06");
    @(posedge clk);
    #1;
    os_req = 1'b0; user_req = 1'b0;
    checks++;
    if ({resp_valid, os_err} !== 2'b00) begin
      errors++;
      $display("FAIL collision_drop got resp_valid=%0b os_err=%0b required 0/0", resp_valid, os_err);
    end
    checks++;
    if ({owned_o, owner_o, rr_ptr_o, all_valid_o} !== {8'h3F, 16'h0FA5, 12'h880, 8'h0F}) begin
      errors++;
      $display("FAIL collision_state got owned=%02h owner=%04h rr=%03h valid=%02h required 3f/0fa5/880/0f",
               owned_o, owner_o, rr_ptr_o, all_valid_o);
    end
  endtask

  task automatic test_async_reset();
    do_user(2'd1, 8'h06, 1'b1, 8'h02);
    user_req = 1'b1; user_domain = 2'd1; addr = 8'h09;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({resp_valid, hit, hit_way, os_err} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset_outputs got %03h required 000", {resp_valid, hit, hit_way, os_err});
    end
    checks++;
    if ({all_tags_o, all_valid_o, owned_o, owner_o, rr_ptr_o} !== '0) begin
      errors++;
      $display("FAIL async_reset_state got valid=%02h owned=%02h rr=%03h required all zero",
               all_valid_o, owned_o, rr_ptr_o);
    end
    @(posedge clk);
    #1;
    user_req = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL pending_lost got resp_valid=%0b required 0", resp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    do_user(2'd1, 8'h06, 1'b0, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_grant_and_hit();
    test_os_err();
    test_replacement();
    test_shrink_regrant();
    test_collision();
    test_async_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d outstanding required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
